rstseq_ctrl: RTL and testbench
==============================

RSTSEQ_CTRL -- requirements
Module: rstseq_ctrl

Interface
REQ-001 Parameter N_DOM, 4, number of downstream reset domains (1..8).
REQ-002 Parameter LOCK_FILT, 4, consecutive synchronized pll_locked=1 cycles required to accept lock (1..16).
REQ-003 Parameter LOCK_WAIT, 1024, clk_sys settle cycles after accepted lock before first release (>=1).
REQ-004 Parameter STEP_DLY, 16, clk_sys cycles between successive domain releases (>=1).
REQ-005 clk_sys  in  1  system clock; sole clock of the block.
REQ-006 rst_n_sys  in  1  reset is asynchronous and active-low.
REQ-007 pll_locked  in  1  PLL lock indicator, asynchronous to clk_sys.
REQ-008 sw_rst_req  in  1  single-cycle soft-reset request pulse, clk_sys domain.
REQ-009 rst_n_dom  out  N_DOM  per-domain active-low resets; bit 0 released first.
REQ-010 seq_busy  out  1  high in every state except S_RUN.
REQ-011 seq_done  out  1  high only in S_RUN.
REQ-012 lock_lost  out  1  sticky: set on lock drop after acceptance; cleared by sw_rst_req.

Function
REQ-013 pll_locked SHALL pass a 2-FF synchronizer; all FSM decisions use the synchronized value (lk_s).
REQ-014 FSM states SHALL be S_WAIT_LOCK, S_SETTLE, S_RELEASE, S_RUN.
REQ-015 S_WAIT_LOCK: filter counter increments while lk_s=1, clears when lk_s=0; reaching LOCK_FILT -> S_SETTLE with cycle counter cleared.
REQ-016 S_SETTLE: after LOCK_WAIT cycles -> S_RELEASE, step counter and domain index cleared.
REQ-017 S_RELEASE: when step counter reaches STEP_DLY-1, rst_n_dom[idx] SHALL go 1 next cycle, idx increments, counter clears; after bit N_DOM-1 released -> S_RUN.
REQ-018 Released bits SHALL stay 1 until an abort; no bit released out of order.
REQ-019 Abort: lk_s=0 in S_SETTLE, S_RELEASE or S_RUN -> all rst_n_dom=0 on next clock, lock_lost=1, -> S_WAIT_LOCK, counters cleared.
REQ-020 Abort: sw_rst_req=1 in any state -> all rst_n_dom=0 on next clock, lock_lost=0, -> S_WAIT_LOCK, counters cleared.
REQ-021 Simultaneous lock drop and sw_rst_req SHALL take the sw_rst_req path except lock_lost SHALL be set to 1.
REQ-022 Counters SHALL be sized by $clog2 of their terminal value and never wrap; they hold/clear per state.
REQ-023 All outputs SHALL be registered; no combinational path input->output.
REQ-024 Lock drop during S_WAIT_LOCK SHALL only clear the filter counter and not set lock_lost.

Reset
REQ-025 On rst_n_sys=0: state S_WAIT_LOCK, rst_n_dom=all 0, seq_busy=1, seq_done=0, lock_lost=0, synchronizer FFs 0, counters 0.
REQ-026 Reset assertion SHALL take effect asynchronously; deassertion is assumed synchronous to clk_sys by the upstream clock/reset generator.
REQ-027 rst_n_sys assertion mid-sequence SHALL restart from S_WAIT_LOCK with no partial release retained.

Structure
REQ-028 Package rstseq_pkg SHALL hold the state encoding constants and default parameter values.
REQ-029 Sub-module rstseq_sync (2-FF synchronizer, async active-low reset to 0) SHALL be instantiated for pll_locked.
REQ-030 Implementation SHALL be one FSM plus filter, settle and step counters; no other clocks.

Verification (N_DOM=4, LOCK_FILT=4, LOCK_WAIT=8, STEP_DLY=3)
REQ-031 Clean power-up: lock high at cycle 10 -> rst_n_dom 0001,0011,0111,1111 at 3-cycle spacing after 2-sync+4 filter+8 settle; seq_done=1 with 1111.
REQ-032 Glitchy lock: lock high 3 cycles, low 1, then high -> filter restarts; release timing measured from final rising edge.
REQ-033 Lock loss in S_RUN -> rst_n_dom=0000 within 3 cycles of pll_locked fall (2 sync+1), lock_lost=1, sequence replays when lock returns.
REQ-034 sw_rst_req during S_RELEASE after 0011 -> 0000 next cycle, lock_lost=0, full replay from filter.
REQ-035 sw_rst_req and lock drop same cycle -> 0000, lock_lost=1, state S_WAIT_LOCK.
REQ-036 rst_n_sys pulse mid-S_SETTLE -> all outputs at reset values immediately, no clock required.

Source files
------------

// File: rtl/rstseq_pkg.sv
// Shared state encoding, default parameter values and counter sizing for the reset sequencer.
// Pure declarations: no logic, no latency, no backpressure.
package rstseq_pkg;

   localparam int N_DOM_DEF     = 4;
   localparam int LOCK_FILT_DEF = 4;
   localparam int LOCK_WAIT_DEF = 1024;
   localparam int STEP_DLY_DEF  = 16;

   typedef enum logic [1:0] {
      S_WAIT_LOCK = 2'd0,
      S_SETTLE    = 2'd1,
      S_RELEASE   = 2'd2,
      S_RUN       = 2'd3
   } state_e;

   // Width needed to hold 0..terminal-1, never narrower than one bit.
   function automatic int cnt_w(input int terminal);
      return (terminal < 2) ? 1 : $clog2(terminal);
   endfunction

endpackage

// File: rtl/rstseq_sync.sv
// Two-flop synchronizer for a single asynchronous level into the local clock domain.
// Latency two clock edges; no backpressure.
module rstseq_sync (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/rstseq_ctrl.sv
// Sequences per-domain reset release after a filtered, settled PLL lock; aborts on lock loss or soft reset.
// All outputs registered, one cycle after the deciding edge; no backpressure.
module rstseq_ctrl
   import rstseq_pkg::*;
#(
   parameter int N_DOM     = N_DOM_DEF,
   parameter int LOCK_FILT = LOCK_FILT_DEF,
   parameter int LOCK_WAIT = LOCK_WAIT_DEF,
   parameter int STEP_DLY  = STEP_DLY_DEF
) (
   input  logic             clk_sys_i,
   input  logic             rst_n_sys_i,
   input  logic             pll_locked_i,
   input  logic             sw_rst_req_i,
   output logic [N_DOM-1:0] rst_n_dom_o,
   output logic             seq_busy_o,
   output logic             seq_done_o,
   output logic             lock_lost_o
);

   localparam int FW = cnt_w(LOCK_FILT);
   localparam int SW = cnt_w(LOCK_WAIT);
   localparam int PW = cnt_w(STEP_DLY);
   localparam int IW = cnt_w(N_DOM);

   state_e           state_q, state_d;
   logic [FW-1:0]    filt_q, filt_d;
   logic [SW-1:0]    settle_q, settle_d;
   logic [PW-1:0]    step_q, step_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [N_DOM-1:0] dom_q, dom_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             lost_q, lost_d;
   logic             lk_s;
   logic             lock_drop;

   rstseq_sync u_lock_sync (
      .clk_i   (clk_sys_i),
      .rst_n_i (rst_n_sys_i),
      .d_i     (pll_locked_i),
      .q_o     (lk_s)
   );

   // A lock drop only counts once lock has been accepted.
   assign lock_drop = (state_q != S_WAIT_LOCK) && !lk_s;

   always_comb begin
      state_d  = state_q;
      filt_d   = filt_q;
      settle_d = settle_q;
      step_d   = step_q;
      idx_d    = idx_q;
      dom_d    = dom_q;
      lost_d   = lost_q;
      if (sw_rst_req_i || lock_drop) begin
         state_d  = S_WAIT_LOCK;
         filt_d   = '0;
         settle_d = '0;
         step_d   = '0;
         idx_d    = '0;
         dom_d    = '0;
         lost_d   = lock_drop;
      end else begin
         case (state_q)
            S_WAIT_LOCK: begin
               if (!lk_s) begin
                  filt_d = '0;
               end else if (filt_q == FW'(LOCK_FILT - 1)) begin
                  filt_d   = '0;
                  settle_d = '0;
                  state_d  = S_SETTLE;
               end else begin
                  filt_d = filt_q + FW'(1);
               end
            end
            S_SETTLE: begin
               if (settle_q == SW'(LOCK_WAIT - 1)) begin
                  step_d  = '0;
                  idx_d   = '0;
                  state_d = S_RELEASE;
               end else begin
                  settle_d = settle_q + SW'(1);
               end
            end
            S_RELEASE: begin
               if (step_q == PW'(STEP_DLY - 1)) begin
                  step_d        = '0;
                  dom_d[idx_q]  = 1'b1;
                  if (idx_q == IW'(N_DOM - 1)) begin
                     state_d = S_RUN;
                  end else begin
                     idx_d = idx_q + IW'(1);
                  end
               end else begin
                  step_d = step_q + PW'(1);
               end
            end
            S_RUN:   state_d = S_RUN;
            default: state_d = S_WAIT_LOCK;
         endcase
      end
      busy_d = (state_d != S_RUN);
      done_d = (state_d == S_RUN);
   end

   always_ff @(posedge clk_sys_i or negedge rst_n_sys_i) begin
      if (!rst_n_sys_i) begin
         state_q  <= S_WAIT_LOCK;
         filt_q   <= '0;
         settle_q <= '0;
         step_q   <= '0;
         idx_q    <= '0;
         dom_q    <= '0;
         busy_q   <= 1'b1;
         done_q   <= 1'b0;
         lost_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         filt_q   <= filt_d;
         settle_q <= settle_d;
         step_q   <= step_d;
         idx_q    <= idx_d;
         dom_q    <= dom_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         lost_q   <= lost_d;
      end
   end

   assign rst_n_dom_o = dom_q;
   assign seq_busy_o  = busy_q;
   assign seq_done_o  = done_q;
   assign lock_lost_o = lost_q;

endmodule

// File: tb/tb_rstseq_ctrl.sv
// Self-checking bench for rstseq_ctrl: directed vector table, async-reset sequences, then random lock/soft-reset traffic.
// Expected values come from constants and a timeline model of the release schedule.
module tb_rstseq_ctrl;

   localparam int N  = 4;
   localparam int LF = 4;
   localparam int LW = 8;
   localparam int SD = 3;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         pll = 1'b0;
   logic         sw = 1'b0;
   logic [N-1:0] dom;
   logic         busy, done, lost;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   rstseq_ctrl #(
      .N_DOM     (N),
      .LOCK_FILT (LF),
      .LOCK_WAIT (LW),
      .STEP_DLY  (SD)
   ) dut (
      .clk_sys_i    (clk),
      .rst_n_sys_i  (rst_n),
      .pll_locked_i (pll),
      .sw_rst_req_i (sw),
      .rst_n_dom_o  (dom),
      .seq_busy_o   (busy),
      .seq_done_o   (done),
      .lock_lost_o  (lost)
   );

   // Timeline model: lock is accepted after LF consecutive synchronized-high samples;
   // domain i is released LW + SD*(i+1) cycles after acceptance.
   bit s1, s2, acc, m_lost;
   int run_len, age;

   task automatic model_reset();
      s1 = 0; s2 = 0; acc = 0; m_lost = 0; run_len = 0; age = 0;
   endtask

   task automatic model_step();
      bit lk;
      lk = s2;
      if (sw) begin
         m_lost = acc && !lk;
         acc = 0; run_len = 0;
      end else if (acc && !lk) begin
         m_lost = 1;
         acc = 0; run_len = 0;
      end else if (!acc) begin
         run_len = lk ? run_len + 1 : 0;
         if (run_len == LF) begin
            acc = 1; age = 0;
         end
      end else begin
         age++;
      end
      s2 = s1;
      s1 = pll;
   endtask

   function automatic int m_nrel();
      int nr;
      if (!acc || age < LW) return 0;
      nr = (age - LW) / SD;
      return (nr > N) ? N : nr;
   endfunction

   function automatic logic [N-1:0] m_dom();
      logic [N-1:0] r;
      r = '0;
      for (int i = 0; i < m_nrel(); i++) r[i] = 1'b1;
      return r;
   endfunction

   task automatic check(input string name, input logic [N-1:0] e_dom,
                        input logic e_busy, input logic e_done, input logic e_lost);
      n_chk++;
      if ({dom, busy, done, lost} !== {e_dom, e_busy, e_done, e_lost}) begin
         n_fail++;
         $display("FAIL %s: got dom=%b busy=%b done=%b lost=%b, want dom=%b busy=%b done=%b lost=%b",
                  name, dom, busy, done, lost, e_dom, e_busy, e_done, e_lost);
      end
   endtask

   // Called at a negedge; applies inputs for n rising edges and returns at a negedge.
   task automatic cycles(input int n, input logic p, input logic s);
      repeat (n) begin
         pll = p;
         sw  = s;
         @(posedge clk);
         model_step();
         @(negedge clk);
      end
   endtask

   task automatic async_reset_pulse(input string name);
      @(posedge clk);
      #2 rst_n = 1'b0;
      model_reset();
      #1 check(name, '0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      int           ncyc;
      logic         p;
      logic         s;
      logic [N-1:0] dom;
      logic         busy;
      logic         done;
      logic         lost;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input int n, input logic p, input logic s, input logic [N-1:0] d,
                      input logic b, input logic dn, input logic l);
      vec_t v;
      v.ncyc = n; v.p = p; v.s = s; v.dom = d; v.busy = b; v.done = dn; v.lost = l;
      tbl.push_back(v);
   endtask

   initial begin
      logic p;
      // power-up release, 3-cycle spacing
      add(10, 0, 0, 4'b0000, 1, 0, 0);
      add(16, 1, 0, 4'b0000, 1, 0, 0);
      add( 1, 1, 0, 4'b0001, 1, 0, 0);
      add( 2, 1, 0, 4'b0001, 1, 0, 0);
      add( 1, 1, 0, 4'b0011, 1, 0, 0);
      add( 3, 1, 0, 4'b0111, 1, 0, 0);
      add( 2, 1, 0, 4'b0111, 1, 0, 0);
      add( 1, 1, 0, 4'b1111, 0, 1, 0);
      // lock loss in run, then replay with sticky lock_lost
      add( 2, 0, 0, 4'b1111, 0, 1, 0);
      add( 1, 0, 0, 4'b0000, 1, 0, 1);
      add(16, 1, 0, 4'b0000, 1, 0, 1);
      add( 1, 1, 0, 4'b0001, 1, 0, 1);
      add( 9, 1, 0, 4'b1111, 0, 1, 1);
      // soft reset clears lock_lost, then soft reset mid-release after 0011
      add( 1, 1, 1, 4'b0000, 1, 0, 0);
      add(14, 1, 0, 4'b0000, 1, 0, 0);
      add( 1, 1, 0, 4'b0001, 1, 0, 0);
      add( 3, 1, 0, 4'b0011, 1, 0, 0);
      add( 1, 1, 1, 4'b0000, 1, 0, 0);
      add(14, 1, 0, 4'b0000, 1, 0, 0);
      add( 1, 1, 0, 4'b0001, 1, 0, 0);
      add( 9, 1, 0, 4'b1111, 0, 1, 0);
      // soft reset coinciding with synchronized lock drop
      add( 2, 0, 0, 4'b1111, 0, 1, 0);
      add( 1, 0, 1, 4'b0000, 1, 0, 1);
      add(20, 0, 0, 4'b0000, 1, 0, 1);
      // glitchy lock: 3 high, 1 low, then steady
      add( 3, 1, 0, 4'b0000, 1, 0, 1);
      add( 1, 0, 0, 4'b0000, 1, 0, 1);
      add(16, 1, 0, 4'b0000, 1, 0, 1);
      add( 1, 1, 0, 4'b0001, 1, 0, 1);
      add( 9, 1, 0, 4'b1111, 0, 1, 1);

      model_reset();
      #12 check("reset_state", '0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[k]) begin
         cycles(tbl[k].ncyc, tbl[k].p, tbl[k].s);
         check($sformatf("vec%0d", k), tbl[k].dom, tbl[k].busy, tbl[k].done, tbl[k].lost);
      end

      // async reset mid-settle must clear everything without a clock edge
      cycles(3, 0, 0);
      check("abort_before_settle", 4'b0000, 1'b1, 1'b0, 1'b1);
      cycles(10, 1, 0);
      check("in_settle", 4'b0000, 1'b1, 1'b0, 1'b1);
      async_reset_pulse("rst_mid_settle");
      cycles(16, 1, 0);
      check("post_rst_hold", 4'b0000, 1'b1, 1'b0, 1'b0);
      cycles(1, 1, 0);
      check("post_rst_first", 4'b0001, 1'b1, 1'b0, 1'b0);
      cycles(3, 1, 0);
      check("post_rst_second", 4'b0011, 1'b1, 1'b0, 1'b0);
      async_reset_pulse("rst_mid_release");
      cycles(16, 1, 0);
      check("no_partial_kept", 4'b0000, 1'b1, 1'b0, 1'b0);
      cycles(1, 1, 0);
      check("replay_first", 4'b0001, 1'b1, 1'b0, 1'b0);

      // random lock dwell, glitches and soft resets against the timeline model
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      p = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         logic pi;
         if ($urandom_range(0, 59) == 0) p = ~p;
         pi = p;
         if ($urandom_range(0, 99) == 0) pi = ~p;
         cycles(1, pi, ($urandom_range(0, 149) == 0));
         check("random", m_dom(), !(m_nrel() == N), (m_nrel() == N), m_lost);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
